// File: rtl/seg_scan_controller_pkg.sv
// Shared helpers for the seven-segment scan path: counter widths,
// PWM phase limit and anode drive polarity.
package seg_scan_controller_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = 1; x < v; x = x << 1) r++;
    return r;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Last PWM phase index for a given brightness resolution.
  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  // Pin level for a lane: lit lanes are driven low when active-low.
  function automatic logic anode_level(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/seg_pwm_prescaler.sv
// Refresh timebase: tick counts clocks within a PWM phase, phase counts
// phases within one digit slot. Both freeze while enable is low.
module seg_pwm_prescaler
  import seg_scan_controller_pkg::*;
#(
  parameter int PHASE_LEN = 1563,
  parameter int PWM_BITS  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [PWM_BITS-1:0] phase,
  output logic                phase_end,
  output logic                slot_end
);

  localparam int                  TICK_W    = cnt_w(PHASE_LEN);
  localparam logic [TICK_W-1:0]   TICK_MAX  = TICK_W'(PHASE_LEN - 1);
  localparam logic [PWM_BITS-1:0] PHASE_MAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic [TICK_W-1:0] tick;

  // Flags describe the current count, i.e. the next enabled edge ends it.
  assign phase_end = (tick == TICK_MAX);
  assign slot_end  = phase_end && (phase == PHASE_MAX);

  // Tick/phase counters, explicitly wrapped so neither overflows its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick  <= '0;
      phase <= '0;
    end else if (enable) begin
      if (phase_end) begin
        tick  <= '0;
        phase <= (phase == PHASE_MAX) ? '0 : phase + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// N-digit anode scanner: walks digit_sel across the lanes one slot at a
// time, PWM-dims the owning lane and pulses frame_tick after each full scan.
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS       = 7,
  parameter int PHASE_LEN        = 1563,
  parameter int PWM_BITS         = 3,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int SEL_W           = cnt_w(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  frame_tick
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic             OFF_LVL  = anode_level(1'b0, ANODE_ACTIVE_LOW);

  logic [PWM_BITS-1:0]   phase;
  logic                  phase_end;
  logic                  slot_end;
  logic                  slot_adv;
  logic                  sel_last;
  logic                  lit;
  logic [PWM_BITS-1:0]   lat_bright;
  logic [NUM_DIGITS-1:0] lat_mask;
  logic [NUM_DIGITS-1:0] drive;

  seg_pwm_prescaler #(
    .PHASE_LEN (PHASE_LEN),
    .PWM_BITS  (PWM_BITS)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .phase     (phase),
    .phase_end (phase_end),
    .slot_end  (slot_end)
  );

  // A slot only ever ends on a phase boundary; advance on enabled edges.
  assign slot_adv = enable && phase_end && slot_end;
  assign sel_last = (digit_sel == SEL_LAST);

  // Lane decode from the current counters and the slot-start latches.
  always_comb begin
    drive = {NUM_DIGITS{OFF_LVL}};
    lit   = enable && !lat_mask[digit_sel] && (phase <= lat_bright);
    for (int i = 0; i < NUM_DIGITS; i++)
      drive[i] = anode_level(lit && (digit_sel == SEL_W'(i)), ANODE_ACTIVE_LOW);
  end

  // Digit pointer, slot-start latches and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_sel  <= '0;
      lat_bright <= '1;
      lat_mask   <= '0;
      anode      <= {NUM_DIGITS{OFF_LVL}};
      frame_tick <= 1'b0;
    end else begin
      anode      <= drive;
      frame_tick <= slot_adv && sel_last;
      if (slot_adv) begin
        digit_sel  <= sel_last ? '0 : digit_sel + 1'b1;
        lat_bright <= brightness;
        lat_mask   <= digit_mask;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller with a 3-digit, 8-clock-slot configuration.
module tb_seg_scan_controller;

  localparam int N     = 3;
  localparam int PL    = 2;
  localparam int PB    = 2;
  localparam int SLOT  = PL * (1 << PB);
  localparam int FRAME = SLOT * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] digit_mask;
  logic [PB-1:0] brightness;
  logic [1:0]   digit_sel;
  logic [N-1:0] anode;
  logic         frame_tick;

  typedef struct packed {
    logic [N-1:0] anode;
    logic [1:0]   sel;
    logic         ft;
  } exp_t;

  exp_t sb[$];

  int cmp_cnt = 0;
  int err_cnt = 0;
  int ft_seen = 0;

  // Reference state: position within the frame plus slot-start latches.
  int            m_pos;
  logic [PB-1:0] m_lb;
  logic [N-1:0]  m_lm;

  seg_scan_controller #(
    .NUM_DIGITS       (N),
    .PHASE_LEN        (PL),
    .PWM_BITS         (PB),
    .ANODE_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digit_mask (digit_mask),
    .brightness (brightness),
    .digit_sel  (digit_sel),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_lb  = '1;
    m_lm  = '0;
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic step();
    exp_t e;
    exp_t got;
    int   d;
    int   ph;
    d       = m_pos / SLOT;
    e.anode = '1;
    e.ft    = 1'b0;
    if (enable) begin
      ph = (m_pos % SLOT) / PL;
      if (!m_lm[d] && (ph <= int'(m_lb))) e.anode[d] = 1'b0;
      e.ft = (m_pos == FRAME - 1);
      if (m_pos % SLOT == SLOT - 1) begin
        m_lb = brightness;
        m_lm = digit_mask;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    e.sel = 2'(m_pos / SLOT);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("anode", 32'(anode), 32'(got.anode));
    chk("digit_sel", 32'(digit_sel), 32'(got.sel));
    chk("frame_tick", 32'(frame_tick), 32'(got.ft));
    if (frame_tick === 1'b1) ft_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    brightness = 2'd3;
    digit_mask = 3'b000;
    model_reset();
    #2;
    chk("rst_anode", 32'(anode), 32'h7);
    chk("rst_sel", 32'(digit_sel), 32'h0);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Full brightness, no mask: two frames, one frame_tick each.
    ft_seen = 0;
    run(2 * FRAME);
    chk("ft_per_2_frames", 32'(ft_seen), 32'd2);

    // Dim settings take effect from the next slot onward.
    brightness = 2'd0;
    run(FRAME);
    brightness = 2'd1;
    run(FRAME + SLOT);

    // Mask lane 1; frame length must not change.
    brightness = 2'd3;
    digit_mask = 3'b010;
    ft_seen    = 0;
    run(2 * FRAME);
    chk("ft_masked", 32'(ft_seen), 32'd2);

    // Brightness change at clock 3 of a slot.
    digit_mask = 3'b000;
    while (m_pos % SLOT != 3) step();
    brightness = 2'd0;
    run(2 * SLOT);
    brightness = 2'd3;
    run(2 * SLOT);

    // Drop enable at clock 5 of digit 1 for 10 clocks.
    while (m_pos != SLOT + 5) step();
    enable  = 1'b0;
    ft_seen = 0;
    run(10);
    chk("hold_sel", 32'(digit_sel), 32'd1);
    chk("hold_no_ft", 32'(ft_seen), 32'd0);
    enable = 1'b1;
    run(FRAME);

    // Async reset mid-slot, between clock edges.
    while (m_pos % SLOT != 4) step();
    reset = 1'b1;
    #1;
    chk("arst_anode", 32'(anode), 32'h7);
    chk("arst_sel", 32'(digit_sel), 32'h0);
    chk("arst_ft", 32'(frame_tick), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_anode", 32'(anode), 32'h7);
    @(negedge clk);
    reset      = 1'b0;
    brightness = 2'd2;
    model_reset();
    run(FRAME + SLOT);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
